// File: rtl/dct8_transpose_pp_if.sv
// Row-in / column-out stream bundle for the ping-pong transpose buffer.
// Master drives rows and output readiness; slave returns columns and status.
interface dct8_transpose_pp_if #(
  parameter int DATA_W = 16,
  parameter int N      = 8
);
  logic                       valid_in;
  logic [N-1:0][DATA_W-1:0]   data_in;
  logic                       in_ready;
  logic                       valid_out;
  logic [N-1:0][DATA_W-1:0]   data_out;
  logic                       last_out;
  logic                       ready_out;
  logic                       overflow;

  modport master (
    output valid_in, data_in, ready_out,
    input  in_ready, valid_out, data_out, last_out, overflow
  );

  modport slave (
    input  valid_in, data_in, ready_out,
    output in_ready, valid_out, data_out, last_out, overflow
  );
endinterface

// File: rtl/dct8_transpose_pp.sv
// Two-bank NxN transpose buffer: rows written into one bank while the other is read out by column.
// Column 0 appears two cycles after the last row; ready_out stalls the output register, full banks drop rows.
module dct8_transpose_pp #(
  parameter int DATA_W = 16,
  parameter int N      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  dct8_transpose_pp_if.slave  io
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef logic [N-1:0][DATA_W-1:0] vec_t;
  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_READING
  } bank_st_e;

  bank_st_e bank_st_q [2];
  bank_st_e bank_st_d [2];

  logic                               wr_sel_q, wr_sel_d;
  logic                               rd_sel_q, rd_sel_d;
  logic [CW-1:0]                      wr_row_q, wr_row_d;
  logic [CW-1:0]                      rd_col_q, rd_col_d;
  logic [1:0][N-1:0][N-1:0][DATA_W-1:0] mem_q, mem_d;
  vec_t                               data_out_q, data_out_d;
  logic                               valid_out_q, valid_out_d;
  logic                               last_out_q, last_out_d;
  logic                               overflow_q, overflow_d;
  logic                               in_ready;
  logic                               rd_avail;
  logic                               out_load;
  vec_t                               rd_col_vec;

  assign in_ready = (bank_st_q[wr_sel_q] == BANK_EMPTY) ||
                    (bank_st_q[wr_sel_q] == BANK_FILLING);
  assign rd_avail = (bank_st_q[rd_sel_q] == BANK_FULL) ||
                    (bank_st_q[rd_sel_q] == BANK_READING);
  assign out_load = !valid_out_q || io.ready_out;

  always_comb begin
    rd_col_vec = '0;
    for (int r = 0; r < N; r++) begin
      rd_col_vec[r] = mem_q[rd_sel_q][r][rd_col_q];
    end
  end

  always_comb begin
    bank_st_d[0] = bank_st_q[0];
    bank_st_d[1] = bank_st_q[1];
    wr_sel_d     = wr_sel_q;
    rd_sel_d     = rd_sel_q;
    wr_row_d     = wr_row_q;
    rd_col_d     = rd_col_q;
    mem_d        = mem_q;
    data_out_d   = data_out_q;
    valid_out_d  = valid_out_q;
    last_out_d   = last_out_q;
    overflow_d   = overflow_q;

    // Write side only ever owns an EMPTY/FILLING bank, read side a FULL/READING one,
    // so the two updates below never touch the same bank state.
    if (io.valid_in) begin
      if (in_ready) begin
        mem_d[wr_sel_q][wr_row_q] = io.data_in;
        if (wr_row_q == LAST_IDX) begin
          bank_st_d[wr_sel_q] = BANK_FULL;
          wr_sel_d            = !wr_sel_q;
          wr_row_d            = '0;
        end else begin
          bank_st_d[wr_sel_q] = BANK_FILLING;
          wr_row_d            = wr_row_q + 1'b1;
        end
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (out_load) begin
      if (rd_avail) begin
        data_out_d  = rd_col_vec;
        valid_out_d = 1'b1;
        last_out_d  = (rd_col_q == LAST_IDX);
        if (rd_col_q == LAST_IDX) begin
          bank_st_d[rd_sel_q] = BANK_EMPTY;
          rd_sel_d            = !rd_sel_q;
          rd_col_d            = '0;
        end else begin
          bank_st_d[rd_sel_q] = BANK_READING;
          rd_col_d            = rd_col_q + 1'b1;
        end
      end else begin
        valid_out_d = 1'b0;
        last_out_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st_q[0] <= BANK_EMPTY;
      bank_st_q[1] <= BANK_EMPTY;
      wr_sel_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      wr_row_q     <= '0;
      rd_col_q     <= '0;
      mem_q        <= '0;
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      last_out_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      bank_st_q[0] <= bank_st_d[0];
      bank_st_q[1] <= bank_st_d[1];
      wr_sel_q     <= wr_sel_d;
      rd_sel_q     <= rd_sel_d;
      wr_row_q     <= wr_row_d;
      rd_col_q     <= rd_col_d;
      mem_q        <= mem_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      last_out_q   <= last_out_d;
      overflow_q   <= overflow_d;
    end
  end

  assign io.in_ready  = in_ready;
  assign io.valid_out = valid_out_q;
  assign io.data_out  = data_out_q;
  assign io.last_out  = last_out_q;
  assign io.overflow  = overflow_q;

endmodule

// File: tb/tb_dct8_transpose_pp.sv
// Directed bench for the ping-pong transpose buffer: latency, streaming, stall, overflow, reset, extremes.
module tb_dct8_transpose_pp;
  localparam int N  = 8;
  localparam int DW = 16;

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef struct {
    vec_t d;
    logic last;
    int   cyc;
  } beat_t;

  logic  clk   = 1'b0;
  logic  rst_n = 1'b1;
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;
  int    last_cyc = 0;
  beat_t beats[$];
  beat_t mon_b;

  dct8_transpose_pp_if #(.DATA_W(DW), .N(N)) io ();

  dct8_transpose_pp #(.DATA_W(DW), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted output beat with the cycle it was presented in.
  always @(negedge clk) begin
    if (rst_n && io.valid_out === 1'b1 && io.ready_out === 1'b1) begin
      mon_b.d    = io.data_out;
      mon_b.last = io.last_out;
      mon_b.cyc  = cyc;
      beats.push_back(mon_b);
    end
  end

  // seed < 0 selects the asymmetric 0x8000/0x7FFF pattern.
  function automatic logic [DW-1:0] pat(int seed, int r, int c);
    if (seed < 0) begin
      if (r > c) return 16'h8000;
      if (r < c) return 16'h7FFF;
      return (r % 2 == 1) ? 16'h8000 : 16'h7FFF;
    end
    return DW'(seed * 64 + 8 * r + c);
  endfunction

  function automatic vec_t row_vec(int seed, int r);
    vec_t v;
    for (int c = 0; c < N; c++) v[c] = pat(seed, r, c);
    return v;
  endfunction

  function automatic vec_t exp_col(int seed, int k);
    vec_t v;
    for (int r = 0; r < N; r++) v[r] = pat(seed, r, k);
    return v;
  endfunction

  task automatic send_row(input int seed, input int r, output logic ir);
    @(posedge clk); #1;
    io.valid_in = 1'b1;
    io.data_in  = row_vec(seed, r);
    ir          = io.in_ready;
    last_cyc    = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      io.valid_in = 1'b0;
      io.data_in  = '0;
    end
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    int t = 0;
    while (beats.size() < n && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    ok = (beats.size() >= n);
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (io.valid_out !== 1'b0 || io.last_out !== 1'b0) begin
      errors++; $display("FAIL reset_valid_last: got %b/%b expected 0/0", io.valid_out, io.last_out);
    end
    checks++;
    if (io.overflow !== 1'b0) begin
      errors++; $display("FAIL reset_overflow: got %b expected 0", io.overflow);
    end
    checks++;
    if (io.data_out !== '0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", io.data_out);
    end
    checks++;
    if (io.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", io.in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_block();
    logic ir;
    bit   ok;
    int   c;
    beats.delete();
    io.ready_out = 1'b1;
    for (int r = 0; r < N; r++) send_row(0, r, ir);
    c = last_cyc;
    idle(1);
    wait_beats(N, 40, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_count: got %0d beats expected %0d", beats.size(), N);
      return;
    end
    checks++;
    if (beats[0].cyc != c + 2) begin
      errors++; $display("FAIL single_latency: got cycle %0d expected %0d", beats[0].cyc, c + 2);
    end
    checks++;
    if (beats[N-1].cyc != c + N + 1) begin
      errors++; $display("FAIL single_last_cycle: got cycle %0d expected %0d", beats[N-1].cyc, c + N + 1);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (beats[k].d !== exp_col(0, k)) begin
        errors++; $display("FAIL single_col%0d: got %h expected %h", k, beats[k].d, exp_col(0, k));
      end
      checks++;
      if (beats[k].last !== (k == N - 1)) begin
        errors++; $display("FAIL single_last%0d: got %b expected %b", k, beats[k].last, (k == N - 1));
      end
    end
    checks++;
    if (io.overflow !== 1'b0) begin
      errors++; $display("FAIL single_overflow: got %b expected 0", io.overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic ir;
    bit   ok;
    int   ir_low = 0;
    int   gaps = 0;
    beats.delete();
    io.ready_out = 1'b1;
    for (int i = 0; i < 3 * N; i++) begin
      send_row(1 + i / N, i % N, ir);
      if (ir !== 1'b1) ir_low++;
    end
    idle(1);
    wait_beats(3 * N, 60, ok);
    checks++;
    if (ir_low != 0) begin
      errors++; $display("FAIL b2b_in_ready: got %0d low cycles expected 0", ir_low);
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_count: got %0d beats expected %0d", beats.size(), 3 * N);
      return;
    end
    for (int i = 1; i < 3 * N; i++) if (beats[i].cyc != beats[0].cyc + i) gaps++;
    checks++;
    if (gaps != 0) begin
      errors++; $display("FAIL b2b_gapless: got %0d gaps expected 0", gaps);
    end
    for (int i = 0; i < 3 * N; i++) begin
      checks++;
      if (beats[i].d !== exp_col(1 + i / N, i % N) || beats[i].last !== (i % N == N - 1)) begin
        errors++; $display("FAIL b2b_col%0d: got %h/%b expected %h/%b", i, beats[i].d, beats[i].last,
                           exp_col(1 + i / N, i % N), (i % N == N - 1));
      end
    end
  endtask

  task automatic test_stall();
    logic ir;
    bit   ok;
    int   c;
    int   bad_hold = 0;
    beats.delete();
    io.ready_out = 1'b1;
    for (int r = 0; r < N; r++) send_row(4, r, ir);
    c = last_cyc;
    idle(1);
    while (cyc < c + 5) begin
      @(posedge clk); #1;
    end
    io.ready_out = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (io.valid_out !== 1'b1 || io.last_out !== 1'b0 || io.data_out !== exp_col(4, 3)) bad_hold++;
      @(posedge clk); #1;
    end
    io.ready_out = 1'b1;
    checks++;
    if (bad_hold != 0) begin
      errors++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad_hold);
    end
    wait_beats(N, 40, ok);
    idle(5);
    checks++;
    if (!ok || beats.size() != N) begin
      errors++; $display("FAIL stall_count: got %0d beats expected %0d", beats.size(), N);
      return;
    end
    checks++;
    if (beats[3].cyc != c + 10 || beats[4].cyc != c + 11) begin
      errors++; $display("FAIL stall_timing: got %0d/%0d expected %0d/%0d", beats[3].cyc, beats[4].cyc, c + 10, c + 11);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (beats[k].d !== exp_col(4, k)) begin
        errors++; $display("FAIL stall_col%0d: got %h expected %h", k, beats[k].d, exp_col(4, k));
      end
    end
  endtask

  task automatic test_overflow();
    logic ir;
    bit   ok;
    beats.delete();
    io.ready_out = 1'b0;
    for (int i = 0; i < 3 * N; i++) begin
      send_row(5 + i / N, i % N, ir);
      checks++;
      if (ir !== (i < 2 * N)) begin
        errors++; $display("FAIL ovf_in_ready_row%0d: got %b expected %b", i, ir, (i < 2 * N));
      end
      if (i == 2 * N) begin
        checks++;
        if (io.overflow !== 1'b0) begin
          errors++; $display("FAIL ovf_early: got %b expected 0", io.overflow);
        end
      end
    end
    idle(3);
    checks++;
    if (io.overflow !== 1'b1 || io.in_ready !== 1'b0) begin
      errors++; $display("FAIL ovf_flag: got %b/%b expected 1/0", io.overflow, io.in_ready);
    end
    io.ready_out = 1'b1;
    wait_beats(2 * N, 80, ok);
    idle(20);
    checks++;
    if (!ok || beats.size() != 2 * N) begin
      errors++; $display("FAIL ovf_count: got %0d beats expected %0d", beats.size(), 2 * N);
      return;
    end
    for (int i = 0; i < 2 * N; i++) begin
      checks++;
      if (beats[i].d !== exp_col(5 + i / N, i % N)) begin
        errors++; $display("FAIL ovf_col%0d: got %h expected %h", i, beats[i].d, exp_col(5 + i / N, i % N));
      end
    end
    checks++;
    if (io.overflow !== 1'b1 || io.in_ready !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %b/%b expected 1/1", io.overflow, io.in_ready);
    end
  endtask

  task automatic test_reset_mid_block();
    logic ir;
    bit   ok;
    io.ready_out = 1'b0;
    for (int r = 0; r < N; r++) send_row(9, r, ir);
    for (int r = 0; r <= 4; r++) send_row(8, r, ir);
    idle(2);
    checks++;
    if (io.valid_out !== 1'b1) begin
      errors++; $display("FAIL rmid_pending: got %b expected 1", io.valid_out);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (io.valid_out !== 1'b0 || io.last_out !== 1'b0 || io.overflow !== 1'b0 || io.data_out !== '0) begin
      errors++; $display("FAIL rmid_async: got v%b l%b o%b d%h expected all zero",
                         io.valid_out, io.last_out, io.overflow, io.data_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    beats.delete();
    io.ready_out = 1'b1;
    for (int r = 0; r < N; r++) send_row(10, r, ir);
    idle(1);
    wait_beats(N, 40, ok);
    idle(20);
    checks++;
    if (!ok || beats.size() != N) begin
      errors++; $display("FAIL rmid_count: got %0d beats expected %0d", beats.size(), N);
      return;
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (beats[k].d !== exp_col(10, k) || beats[k].last !== (k == N - 1)) begin
        errors++; $display("FAIL rmid_col%0d: got %h expected %h", k, beats[k].d, exp_col(10, k));
      end
    end
  endtask

  task automatic test_extremes();
    logic ir;
    bit   ok;
    beats.delete();
    io.ready_out = 1'b1;
    for (int r = 0; r < N; r++) send_row(-1, r, ir);
    idle(1);
    wait_beats(N, 40, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL ext_count: got %0d beats expected %0d", beats.size(), N);
      return;
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (beats[k].d !== exp_col(-1, k)) begin
        errors++; $display("FAIL ext_col%0d: got %h expected %h", k, beats[k].d, exp_col(-1, k));
      end
    end
  endtask

  initial begin
    io.valid_in  = 1'b0;
    io.data_in   = '0;
    io.ready_out = 1'b0;
    test_reset();
    test_single_block();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_reset_mid_block();
    test_extremes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
